// File: rtl/pwm_duty_capture.sv
// PWM receiver: recovers high time and period (in clk cycles) of pwm_in and flags stuck levels.
// Define GLITCH_FILTER_EN to reject input pulses shorter than 2 clk (adds 1 clk of edge latency).
module pwm_duty_capture #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 256  // must satisfy 2 <= TIMEOUT <= 2**CNT_W-1 so counters never wrap
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             lvl;
  logic             lvl_use;
  logic             rise;
  logic [CNT_W-1:0] per_c;
  logic [CNT_W-1:0] hi_c;
  logic             timed_out;

  assign lvl = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pwm_in};
    end
  end

`ifdef GLITCH_FILTER_EN
  logic lvl_f;
  logic lvl_f_prev;

  // Accept a new level only once the next synchronizer stage agrees with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_f      <= 1'b0;
      lvl_f_prev <= 1'b0;
    end else begin
      lvl_f_prev <= lvl_f;
      if (lvl == sync[0]) begin
        lvl_f <= lvl;
      end
    end
  end

  assign lvl_use = lvl_f;
  assign rise    = lvl_f & ~lvl_f_prev;
`else
  logic lvl_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_prev <= 1'b0;
    end else begin
      lvl_prev <= lvl;
    end
  end

  assign lvl_use = lvl;
  assign rise    = lvl & ~lvl_prev;
`endif

  // timed_out makes the stuck report fire once; the counter then holds at TO until a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      per_c      <= '0;
      hi_c       <= '0;
      timed_out  <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        if (state == MEAS) begin
          high_cnt   <= hi_c;
          period_cnt <= per_c;
          meas_valid <= 1'b1;
          stuck_hi   <= 1'b0;
          stuck_lo   <= 1'b0;
        end
        state     <= MEAS;
        per_c     <= ONE;
        hi_c      <= ONE;
        timed_out <= 1'b0;
      end else if (per_c == TO) begin
        if (!timed_out) begin
          period_cnt <= TO;
          high_cnt   <= lvl_use ? TO : '0;
          stuck_hi   <= lvl_use;
          stuck_lo   <= ~lvl_use;
          meas_valid <= 1'b1;
          timed_out  <= 1'b1;
        end
        state <= IDLE;
      end else begin
        per_c <= per_c + ONE;
        if (state == MEAS) begin
          hi_c <= hi_c + {{(CNT_W-1){1'b0}}, lvl_use};
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: waveforms are built as bit queues, the expected reports are
// derived from the rise positions in each waveform, and every meas_valid pulse is scored.
module tb_pwm_duty_capture;
  localparam int CNT_W = 10;
  localparam int T     = 256;
  localparam int W     = 2 * CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_hi;
  logic             stuck_lo;

  int         total = 0;
  int         bad = 0;
  bit         sb_on = 1'b0;
  logic [W-1:0] exp_q[$];
  bit         wave[$];

  pwm_duty_capture #(.CNT_W(CNT_W), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit sh, input bit sl, input int hi, input int per);
    return {sh, sl, CNT_W'(hi), CNT_W'(per)};
  endfunction

  // waveform builders
  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic add_pwm(input int h, input int p);
    add_level(1'b1, h);
    add_level(1'b0, p - h);
  endtask

  task automatic add_tail();
    add_level(1'b0, T + 20);
  endtask

  // Reference model: every pair of consecutive rises yields one report; a gap above T
  // becomes a stuck report at the level seen T cycles after the earlier rise.
  // With no rise early enough after reset, the idle counter reports stuck low first.
  task automatic build_expect();
    int rises[$];
    exp_q.delete();
    for (int i = 0; i < wave.size(); i++)
      if (wave[i] && (i == 0 || !wave[i-1])) rises.push_back(i);
    if (rises.size() == 0 || rises[0] > T - 3) exp_q.push_back(pack(1'b0, 1'b1, 0, T));
    for (int k = 0; k < rises.size(); k++) begin
      int r;
      int gap;
      int ones;
      r    = rises[k];
      gap  = (k + 1 < rises.size()) ? rises[k+1] - r : T + 1;
      ones = 0;
      if (gap <= T) begin
        for (int j = r; j < r + gap; j++) ones += int'(wave[j]);
        exp_q.push_back(pack(1'b0, 1'b0, ones, gap));
      end else if (wave[r+T]) begin
        exp_q.push_back(pack(1'b1, 1'b0, T, T));
      end else begin
        exp_q.push_back(pack(1'b0, 1'b1, 0, T));
      end
    end
  endtask

  // driver
  task automatic drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk);
      pwm_in = wave[i];
    end
  endtask

  task automatic run_segment(input bit do_reset);
    if (do_reset) apply_reset(1);
    build_expect();
    sb_on = 1'b1;
    drive_wave();
    sb_on = 1'b0;
    check("drain", exp_q.size(), 0);
    wave.delete();
  endtask

  task automatic add_random_chunks(input int n);
    for (int c = 0; c < n; c++) begin
      int kind;
      int p;
      int g;
      kind = $urandom_range(0, 3);
      wave.push_back(1'b0);
      case (kind)
        0: begin
          p = $urandom_range(2, 80);
          g = $urandom_range(1, p - 1);
          repeat ($urandom_range(3, 6)) add_pwm(g, p);
        end
        1: begin
          repeat ($urandom_range(20, 60)) wave.push_back(1'($urandom_range(0, 1)));
        end
        2: begin
          add_level(1'b1, $urandom_range(T - 3, T + 40));
          wave.push_back(1'b0);
        end
        default: begin
          g = $urandom_range(T - 1, T + 1);
          wave.push_back(1'b1);
          add_level(1'b0, g - 1);
          wave.push_back(1'b1);
          wave.push_back(1'b0);
        end
      endcase
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (sb_on && rst_n && meas_valid) begin
      check("meas_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("meas", {stuck_hi, stuck_lo, high_cnt, period_cnt}, exp_q.pop_front());
    end
  end

  initial begin
    apply_reset(3);
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_stuck_hi", stuck_hi, 0);
    check("rst_stuck_lo", stuck_lo, 0);

    // 32/64 loopback frame
    add_level(1'b0, 5);
    repeat (6) add_pwm(32, 64);
    add_tail();
    run_segment(1'b0);

    // ref 63 and ref 1
    add_level(1'b0, 5);
    repeat (5) add_pwm(63, 64);
    add_tail();
    run_segment(1'b1);
    add_level(1'b0, 5);
    repeat (5) add_pwm(1, 64);
    add_tail();
    run_segment(1'b1);

    // held high after one rise
    add_level(1'b0, 5);
    add_level(1'b1, 300);
    add_tail();
    run_segment(1'b1);

    // held low from reset, then PWM restarts
    add_level(1'b0, 300);
    repeat (4) add_pwm(32, 64);
    add_tail();
    run_segment(1'b1);

    // 1-clk glitch in the low phase
    add_level(1'b0, 5);
    repeat (2) add_pwm(32, 64);
    add_level(1'b1, 32);
    add_level(1'b0, 10);
    add_level(1'b1, 1);
    add_level(1'b0, 21);
    repeat (2) add_pwm(32, 64);
    add_tail();
    run_segment(1'b1);

    // rise exactly at the timeout (rise wins), then one cycle past it
    add_level(1'b0, 5);
    wave.push_back(1'b1);
    add_level(1'b0, T - 1);
    wave.push_back(1'b1);
    add_level(1'b0, T);
    wave.push_back(1'b1);
    wave.push_back(1'b0);
    repeat (2) add_pwm(10, 20);
    add_tail();
    run_segment(1'b1);

    // reset pulse in the middle of a high phase
    apply_reset(1);
    add_level(1'b0, 5);
    repeat (3) add_pwm(32, 64);
    add_level(1'b1, 20);
    drive_wave();
    wave.delete();
    apply_reset(1);
    check("mid_rst_high_cnt", high_cnt, 0);
    check("mid_rst_period_cnt", period_cnt, 0);
    check("mid_rst_meas_valid", meas_valid, 0);
    check("mid_rst_stuck_hi", stuck_hi, 0);
    check("mid_rst_stuck_lo", stuck_lo, 0);
    add_level(1'b0, 5);
    repeat (3) add_pwm(32, 64);
    add_tail();
    run_segment(1'b0);

    // randomized segments
    for (int s = 0; s < 10; s++) begin
      add_level(1'b0, $urandom_range(5, 30));
      add_random_chunks($urandom_range(3, 7));
      add_tail();
      run_segment(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
